// File: rtl/wb_pkg.sv
// Shared types for the writeback commit queue: register-file geometry,
// the queued pair entry and the lane qualification / collision rule.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Result field width carried in an entry; the queue's DATA_WIDTH must match.
  localparam int RES_W      = 32;

  // One queued result pair: lane A is the older instruction, lane B the younger.
  typedef struct packed {
    logic                  weA;
    logic [REG_ADDR_W-1:0] rdA;
    logic [RES_W-1:0]      resA;
    logic                  weB;
    logic [REG_ADDR_W-1:0] rdB;
    logic [RES_W-1:0]      resB;
  } wb_entry_t;

  // Build an entry from raw lane inputs. A lane writes only when enabled and
  // not targeting x0. If both lanes target the same register, the younger
  // lane B wins, so a pair never writes one register twice.
  function automatic wb_entry_t resolve_pair(
    input logic                  reg_write_a,
    input logic [REG_ADDR_W-1:0] rd_a,
    input logic [RES_W-1:0]      res_a,
    input logic                  reg_write_b,
    input logic [REG_ADDR_W-1:0] rd_b,
    input logic [RES_W-1:0]      res_b
  );
    wb_entry_t e;
    e.weA  = reg_write_a && (rd_a != '0);
    e.rdA  = rd_a;
    e.resA = res_a;
    e.weB  = reg_write_b && (rd_b != '0);
    e.rdB  = rd_b;
    e.resB = res_b;
    if (e.weA && e.weB && (rd_a == rd_b)) begin
      e.weA = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register pending-write counters. Each architectural register x1..x31
// counts the queued writes targeting it; x0 is never written so it has no
// counter and its busy bit is tied low.
module busy_scoreboard
  import wb_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_we_a,
  input  logic [REG_ADDR_W-1:0] enq_rd_a,
  input  logic                  enq_we_b,
  input  logic [REG_ADDR_W-1:0] enq_rd_b,
  input  logic                  drn_we_a,
  input  logic [REG_ADDR_W-1:0] drn_rd_a,
  input  logic                  drn_we_b,
  input  logic [REG_ADDR_W-1:0] drn_rd_b,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy
);

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    // A resolved pair never names one register in both lanes, so each side
    // contributes at most one increment and one decrement per cycle.
    assign inc = (enq_we_a && (enq_rd_a == REG_ADDR_W'(r))) ||
                 (enq_we_b && (enq_rd_b == REG_ADDR_W'(r)));
    assign dec = (drn_we_a && (drn_rd_a == REG_ADDR_W'(r))) ||
                 (drn_we_b && (drn_rd_b == REG_ADDR_W'(r)));

    // Counter update: flush clears, simultaneous enqueue and drain cancel out.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (flush) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
        cnt <= cnt - 1'b1;
      end
    end

    assign busy[r] = (cnt != '0);
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Dual-lane writeback commit queue. Buffers up to DEPTH result pairs between
// execute/memory and the register file, drains one pair per cycle onto the
// two write ports and publishes which registers have uncommitted writes.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PairValid_i,
  output logic                    PairReady_o,
  input  logic                    RegWriteA_i,
  input  logic [REG_ADDR_W-1:0]   RdA_i,
  input  logic [DATA_WIDTH-1:0]   ResultA_i,
  input  logic                    RegWriteB_i,
  input  logic [REG_ADDR_W-1:0]   RdB_i,
  input  logic [DATA_WIDTH-1:0]   ResultB_i,
  input  logic                    Hold_i,
  input  logic                    Flush_i,
  output logic [1:0]              RegWrite_o,
  output logic [REG_ADDR_W-1:0]   RdA_o,
  output logic [REG_ADDR_W-1:0]   RdB_o,
  output logic [DATA_WIDTH-1:0]   ResultA_o,
  output logic [DATA_WIDTH-1:0]   ResultB_o,
  output logic [NUM_REGS-1:0]     Busy_o,
  output logic [$clog2(DEPTH):0]  Count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        entries [DEPTH];
  wb_entry_t        head_e;
  wb_entry_t        new_e;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Lane qualification and same-destination resolution happen on the way in,
  // so everything downstream sees final write enables.
  assign new_e = resolve_pair(RegWriteA_i, RdA_i, RES_W'(ResultA_i),
                              RegWriteB_i, RdB_i, RES_W'(ResultB_i));

  assign head_e = entries[head_ptr];

  // Ready comes from the registered count only: a full queue refuses a pair
  // even when it drains in the same cycle.
  assign PairReady_o = (count != CNT_W'(DEPTH));

  // Flush overrides both enqueue and drain.
  assign push = PairValid_i && PairReady_o && !Flush_i;
  assign pop  = (count != '0) && !Hold_i && !Flush_i;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (Flush_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the write-port address and data
  // outputs start at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (push) begin
      entries[tail_ptr] <= new_e;
    end
  end

  // Write enables are the only outputs with a combinational input path
  // (Hold_i / Flush_i gate the drain).
  always_comb begin
    RegWrite_o = 2'b00;
    if (pop) begin
      RegWrite_o = {head_e.weB, head_e.weA};
    end
  end

  assign RdA_o     = head_e.rdA;
  assign RdB_o     = head_e.rdB;
  assign ResultA_o = head_e.resA[DATA_WIDTH-1:0];
  assign ResultB_o = head_e.resB[DATA_WIDTH-1:0];
  assign Count_o   = count;

  busy_scoreboard #(
    .CNT_W (CNT_W)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .enq_we_a (push && new_e.weA),
    .enq_rd_a (new_e.rdA),
    .enq_we_b (push && new_e.weB),
    .enq_rd_b (new_e.rdB),
    .drn_we_a (pop && head_e.weA),
    .drn_rd_a (head_e.rdA),
    .drn_we_b (pop && head_e.weB),
    .drn_rd_b (head_e.rdB),
    .flush    (Flush_i),
    .busy     (Busy_o)
  );

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: directed scenarios followed by randomized
// traffic, all compared against a queue-of-pairs reference model.
module tb_wb_commit_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          PairValid_i;
  logic          PairReady_o;
  logic          RegWriteA_i;
  logic [4:0]    RdA_i;
  logic [DW-1:0] ResultA_i;
  logic          RegWriteB_i;
  logic [4:0]    RdB_i;
  logic [DW-1:0] ResultB_i;
  logic          Hold_i;
  logic          Flush_i;
  logic [1:0]    RegWrite_o;
  logic [4:0]    RdA_o;
  logic [4:0]    RdB_o;
  logic [DW-1:0] ResultA_o;
  logic [DW-1:0] ResultB_o;
  logic [31:0]   Busy_o;
  logic [2:0]    Count_o;

  wb_commit_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .PairValid_i (PairValid_i),
    .PairReady_o (PairReady_o),
    .RegWriteA_i (RegWriteA_i),
    .RdA_i       (RdA_i),
    .ResultA_i   (ResultA_i),
    .RegWriteB_i (RegWriteB_i),
    .RdB_i       (RdB_i),
    .ResultB_i   (ResultB_i),
    .Hold_i      (Hold_i),
    .Flush_i     (Flush_i),
    .RegWrite_o  (RegWrite_o),
    .RdA_o       (RdA_o),
    .RdB_o       (RdB_o),
    .ResultA_o   (ResultA_o),
    .ResultB_o   (ResultB_o),
    .Busy_o      (Busy_o),
    .Count_o     (Count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        wa;
    bit [4:0]  ra;
    bit [31:0] da;
    bit        wb;
    bit [4:0]  rb;
    bit [31:0] db;
  } pair_t;

  pair_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit wa, input bit [4:0] ra, input bit [31:0] da,
                       input bit wb, input bit [4:0] rb, input bit [31:0] db,
                       input bit hold, input bit flush);
    PairValid_i = v;
    RegWriteA_i = wa; RdA_i = ra; ResultA_i = da;
    RegWriteB_i = wb; RdB_i = rb; ResultB_i = db;
    Hold_i = hold; Flush_i = flush;
  endtask

  // Compare outputs against the model mid-cycle, advance the model, then
  // move to just after the next rising edge so the caller can drive again.
  task automatic cycle();
    int          n;
    bit [31:0]   eb;
    bit          drain;
    bit [1:0]    ewe;
    pair_t       e;
    @(negedge clk);
    n = q.size();
    eb = '0;
    foreach (q[i]) begin
      if (q[i].wa) eb[q[i].ra] = 1'b1;
      if (q[i].wb) eb[q[i].rb] = 1'b1;
    end
    drain = (n > 0) && !Hold_i && !Flush_i;
    ewe = drain ? {q[0].wb, q[0].wa} : 2'b00;
    chk("ready", PairReady_o, n != DEPTH);
    chk("count", Count_o, n);
    chk("busy", Busy_o, eb);
    chk("regwrite", RegWrite_o, ewe);
    if (n > 0) begin
      chk("rdA", RdA_o, q[0].ra);
      chk("rdB", RdB_o, q[0].rb);
      chk("resA", ResultA_o, q[0].da);
      chk("resB", ResultB_o, q[0].db);
    end
    if (Flush_i) begin
      q.delete();
    end else begin
      if (drain) void'(q.pop_front());
      if (PairValid_i && n != DEPTH) begin
        e.wa = RegWriteA_i && (RdA_i != 0);
        e.wb = RegWriteB_i && (RdB_i != 0);
        if (e.wa && e.wb && RdA_i == RdB_i) e.wa = 1'b0;
        e.ra = RdA_i; e.da = ResultA_i;
        e.rb = RdB_i; e.db = ResultB_i;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_regwrite"}, RegWrite_o, 2'b00);
    chk({tag, "_count"}, Count_o, 0);
    chk({tag, "_busy"}, Busy_o, 0);
    chk({tag, "_ready"}, PairReady_o, 1);
    chk({tag, "_rdA"}, RdA_o, 0);
    chk({tag, "_rdB"}, RdB_o, 0);
    chk({tag, "_resA"}, ResultA_o, 0);
    chk({tag, "_resB"}, ResultB_o, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single pair, both lanes writing.
    drive(1, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0); cycle();
    idle(3);

    // Same destination: lane B wins.
    drive(1, 1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0); cycle();
    idle(2);

    // x0 on lane A, lane B disabled.
    drive(1, 1, 0, 32'h33, 0, 8, 32'h44, 0, 0); cycle();
    idle(2);

    // Fill under hold, offer a fifth pair, then release.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'(10 + i), 32'h100 + i, 1, 5'(20 + i), 32'h200 + i, 1, 0);
      cycle();
    end
    idle(6);

    // Three in-flight writes to x9.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 9, 32'h900 + i, 0, 0, 0, 1, 0);
      cycle();
    end
    idle(5);

    // Flush with three queued pairs and a simultaneous offer.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(3 + i), 32'h300 + i, 1, 5'(12 + i), 32'h400 + i, 1, 0);
      cycle();
    end
    drive(1, 1, 17, 32'h777, 1, 18, 32'h888, 0, 1); cycle();
    idle(2);

    // Randomized traffic with small register range to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      cycle();
      if (i == 300) begin
        // Asynchronous reset mid-operation.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
      end
    end
    idle(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
